// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding, parameter
// defaults and small helpers.
// Latency: n/a (declarations only). Backpressure: n/a.
package pll_reset_sequencer_pkg;

  // Default timing, in refclk cycles.
  localparam int PLL_RST_CYCLES_DEF      = 16;
  localparam int LOCK_STABLE_CYCLES_DEF  = 1024;
  localparam int LOCK_TIMEOUT_CYCLES_DEF = 65536;
  localparam int CORE_HOLD_CYCLES_DEF    = 64;
  // Shared down-counter width; 2^CNT_W must exceed every cycle parameter.
  localparam int CNT_W_DEF               = 17;

  localparam int RELOCK_W = 8;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_HOLD      = 3'd3,
    ST_RUN       = 3'd4
  } seq_state_e;

  // Saturating increment for the lock-loss counter.
  function automatic logic [RELOCK_W-1:0] sat_inc(input logic [RELOCK_W-1:0] v);
    return (v == {RELOCK_W{1'b1}}) ? v : v + RELOCK_W'(1);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// PLL-side and core-side signals of the reset sequencer, bundled.
// master = sequencer (samples pll_locked, drives resets/status); slave = PLL/core side.
// Latency/backpressure: n/a (wiring only).
interface pll_reset_sequencer_if;
  import pll_reset_sequencer_pkg::*;

  logic                pll_locked;    // PLL lock indicator, asynchronous to refclk
  logic                pll_rst;       // active-high PLL reset
  logic                core_rst_n;    // active-low core reset
  logic                ready;         // sequencer is in RUN
  logic [RELOCK_W-1:0] relock_count;  // saturating count of lock losses in RUN

  modport master (
    input  pll_locked,
    output pll_rst, core_rst_n, ready, relock_count
  );

  modport slave (
    output pll_locked,
    input  pll_rst, core_rst_n, ready, relock_count
  );
endinterface

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Generic 2-flop single-bit synchronizer with asynchronous active-low clear.
// Latency: 2 i_clk cycles from i_d to o_q. Backpressure: none (level signal).
// Ports: i_clk, i_rst_n (clears both stages to 0), i_d (async input), o_q (synchronized).
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Power-on / lock-loss sequencer: pulses the PLL reset, qualifies lock, then releases core reset.
// Latency: lock loss in RUN drops core_rst_n 3 refclk cycles after pll_locked falls.
// Backpressure: none; retries PLL reset indefinitely on lock timeout.
// Ports: refclk (free-running reference), rst_n (async active-low), bus (master modport:
//        pll_locked in; pll_rst, core_rst_n, ready, relock_count out).
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = PLL_RST_CYCLES_DEF,
  parameter int LOCK_STABLE_CYCLES  = LOCK_STABLE_CYCLES_DEF,
  parameter int LOCK_TIMEOUT_CYCLES = LOCK_TIMEOUT_CYCLES_DEF,
  parameter int CORE_HOLD_CYCLES    = CORE_HOLD_CYCLES_DEF,
  parameter int CNT_W               = CNT_W_DEF
) (
  input logic                   refclk,
  input logic                   rst_n,
  pll_reset_sequencer_if.master bus
);

  localparam logic [2:0] S_PLL_RST   = ST_PLL_RST;
  localparam logic [2:0] S_WAIT_LOCK = ST_WAIT_LOCK;
  localparam logic [2:0] S_STABLE    = ST_STABLE;
  localparam logic [2:0] S_HOLD      = ST_HOLD;
  localparam logic [2:0] S_RUN       = ST_RUN;

  // Counter reload values: a state lasting N cycles loads N-1 and leaves when it reads 0.
  localparam logic [CNT_W-1:0] LD_PLL_RST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_TIMEOUT = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_STABLE  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_HOLD    = CNT_W'(CORE_HOLD_CYCLES - 1);

  logic [2:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_pll_rst;
  logic                r_core_rst_n;
  logic                r_ready;
  logic [RELOCK_W-1:0] r_relock;

  logic [2:0]          w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_relock_inc;
  logic                w_expired;
  logic                w_lock_s;

  sync_2ff u_lock_sync (
    .i_clk   (refclk),
    .i_rst_n (rst_n),
    .i_d     (bus.pll_locked),
    .o_q     (w_lock_s)
  );

  assign w_expired = (r_cnt == '0);

  // Every lock_s check precedes the expiry check so that a lock drop
  // coinciding with expiry takes the lock-loss path.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = w_expired ? r_cnt : r_cnt - CNT_W'(1);
    w_relock_inc = 1'b0;
    case (r_state)
      S_PLL_RST: begin
        if (w_expired) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = LD_TIMEOUT;
        end
      end
      S_WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_nxt = S_STABLE;
          w_cnt_nxt   = LD_STABLE;
        end else if (w_expired) begin
          w_state_nxt = S_PLL_RST;
          w_cnt_nxt   = LD_PLL_RST;
        end
      end
      S_STABLE: begin
        // A glitch restarts qualification without re-resetting the PLL.
        if (!w_lock_s) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = LD_TIMEOUT;
        end else if (w_expired) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = LD_HOLD;
        end
      end
      S_HOLD: begin
        if (!w_lock_s) begin
          w_state_nxt = S_PLL_RST;
          w_cnt_nxt   = LD_PLL_RST;
        end else if (w_expired) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        if (!w_lock_s) begin
          w_state_nxt  = S_PLL_RST;
          w_cnt_nxt    = LD_PLL_RST;
          w_relock_inc = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_PLL_RST;
        w_cnt_nxt   = LD_PLL_RST;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state register.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_PLL_RST;
      r_cnt        <= LD_PLL_RST;
      r_pll_rst    <= 1'b1;
      r_core_rst_n <= 1'b0;
      r_ready      <= 1'b0;
      r_relock     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_pll_rst    <= (w_state_nxt == S_PLL_RST);
      r_core_rst_n <= (w_state_nxt == S_RUN);
      r_ready      <= (w_state_nxt == S_RUN);
      if (w_relock_inc) begin
        r_relock <= sat_inc(r_relock);
      end
    end
  end

  assign bus.pll_rst      = r_pll_rst;
  assign bus.core_rst_n   = r_core_rst_n;
  assign bus.ready        = r_ready;
  assign bus.relock_count = r_relock;

endmodule
